io_bus_arbiter: RTL

Shares the J1 peripheral I/O bus between the J1 CPU (master 0) and an auxiliary bus master (master 1, e.g. the motor-control sequencer or a DMA engine). It also owns the page decode that drives the one-hot peripheral chip-selects and the read-data return mux. It sits between `cpu0` and the peripheral instances in the SoC top. J1 cannot be stalled, so it always wins; master 1 is served in J1 idle cycles through a req/ack handshake.

---
 rtl/io_map_pkg.sv | 15 +
 rtl/io_page_decoder.sv | 18 +
 rtl/io_bus_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/io_map_pkg.sv
// io_map_pkg: J1 I/O page map, chip-select bit positions and master-1 FSM states.
package io_map_pkg;
  localparam logic [7:0] PAGE_MULT  = 8'h67;
  localparam logic [7:0] PAGE_DIV   = 8'h68;
  localparam logic [7:0] PAGE_UART  = 8'h69;
  localparam logic [7:0] PAGE_DPRAM = 8'h70;
  localparam logic [7:0] PAGE_MOTOR = 8'h73;
  localparam int CS_MULT  = 0;
  localparam int CS_DIV   = 1;
  localparam int CS_UART  = 2;
  localparam int CS_DPRAM = 3;
  localparam int CS_MOTOR = 4;
  localparam logic [15:0] RDATA_DEFAULT = 16'h0666;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} m1_state_t;
endpackage

// File: rtl/io_page_decoder.sv
// io_page_decoder: I/O page number to one-hot peripheral chip-select plus mapped flag.
module io_page_decoder
  import io_map_pkg::*;
(
  input  logic [7:0] page,
  output logic [4:0] cs,
  output logic       mapped
);
  always_comb begin
    cs = '0;
    cs[CS_MULT]  = page == PAGE_MULT;
    cs[CS_DIV]   = page == PAGE_DIV;
    cs[CS_UART]  = page == PAGE_UART;
    cs[CS_DPRAM] = page == PAGE_DPRAM;
    cs[CS_MOTOR] = page == PAGE_MOTOR;
    mapped = |cs;
  end
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: shares the J1 I/O bus with an auxiliary master; J1 always wins,
// master 1 is served in J1 idle cycles via req/ack.
module io_bus_arbiter
  import io_map_pkg::*;
#(
  parameter int unsigned  STARVE_MAX    = 255,
  parameter logic [15:0]  DEFAULT_RDATA = RDATA_DEFAULT
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        j1_io_rd,
  input  logic        j1_io_wr,
  input  logic [15:0] j1_io_addr,
  input  logic [15:0] j1_io_dout,
  output logic [15:0] j1_io_din,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [15:0] m1_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_dout,
  output logic [4:0]  cs,
  input  logic [15:0] mult_dout,
  input  logic [15:0] div_dout,
  input  logic [15:0] dpram_dout,
  input  logic [15:0] ctrl_mov_dout,
  input  logic        uart_dout,
  output logic        starve_flag,
  input  logic        starve_clr
);
  localparam logic [7:0] SM8 = 8'(STARVE_MAX);
  m1_state_t   state;
  logic [7:0]  wait_cnt, cnt_inc;
  logic [4:0]  bus_cs, m1_cs;
  logic        bus_mapped, m1_mapped, j1_act, m1_serve, m1_stall;
  logic [15:0] rd_mux;
  io_page_decoder u_bus_dec (.page(bus_addr[15:8]), .cs(bus_cs), .mapped(bus_mapped));
  io_page_decoder u_m1_dec  (.page(m1_addr[15:8]),  .cs(m1_cs),  .mapped(m1_mapped));
  assign j1_act   = j1_io_rd | j1_io_wr;
  assign m1_serve = state == ST_WAIT && m1_req && m1_mapped && !j1_act;
  assign m1_stall = state == ST_WAIT && m1_req && m1_mapped && j1_act;
  assign cnt_inc  = wait_cnt == SM8 ? wait_cnt : wait_cnt + 8'd1;
  always_comb begin
    bus_rd   = j1_act ? j1_io_rd : m1_serve & ~m1_we;
    bus_wr   = j1_act ? j1_io_wr : m1_serve & m1_we;
    bus_addr = j1_act ? j1_io_addr : m1_serve ? m1_addr : '0;
    bus_dout = j1_act ? j1_io_dout : m1_serve ? m1_wdata : '0;
    cs       = m1_serve ? m1_cs : bus_cs;
    rd_mux   = !bus_mapped ? DEFAULT_RDATA :
               ({16{cs[CS_MULT]}}  & mult_dout)  |
               ({16{cs[CS_DIV]}}   & div_dout)   |
               ({16{cs[CS_UART]}}  & {15'b0, uart_dout}) |
               ({16{cs[CS_DPRAM]}} & dpram_dout) |
               ({16{cs[CS_MOTOR]}} & ctrl_mov_dout);
    j1_io_din = rd_mux;
  end
  // Only cycles actually lost to J1 count toward starvation; a set outranks a clear.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      m1_rdata    <= '0;
      starve_flag <= 1'b0;
    end else begin
      m1_ack      <= 1'b0;
      m1_err      <= 1'b0;
      starve_flag <= (m1_stall && cnt_inc == SM8) | (starve_flag & ~starve_clr);
      case (state)
        ST_IDLE: if (m1_req) state <= ST_WAIT;
        ST_WAIT: begin
          if (!m1_req) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else if (!m1_mapped || m1_serve) begin
            state    <= ST_ACK;
            wait_cnt <= '0;
            m1_ack   <= 1'b1;
            m1_err   <= !m1_mapped;
            if (m1_serve && !m1_we) m1_rdata <= rd_mux;
          end else wait_cnt <= cnt_inc;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
